// File: rtl/multicycle_control_unit.sv
// Moore control FSM sequencing the multi-cycle MIPS datapath over 3-5 cycles per instruction.
// Optional memory wait states: define UC_MEM_HANDSHAKE_EN to stall FETCH/MEMREAD/MEMWRITE on i_mem_ready.
module multicycle_control_unit #(
  parameter int ALUOP_W = 2,
  parameter int STATE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [5:0]         i_opcode,
  input  logic               i_mem_ready,
  output logic               o_pc_write,
  output logic               o_pc_write_cond,
  output logic               o_branch_ne,
  output logic               o_iord,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_ir_write,
  output logic               o_mem_to_reg,
  output logic               o_reg_dst,
  output logic               o_reg_write,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_pc_source,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_illegal_op,
  output logic               o_instr_done,
  output logic [STATE_W-1:0] o_state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_IARTH = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b100010;
  localparam logic [5:0] OP_LWI   = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADDR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC_R   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXEC_I   = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_LOADIMM  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_LIWB     = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_ILLEGAL  = STATE_W'(13);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic [5:0]         r_opcode;
  logic               w_mem_ok;
  logic [1:0]         w_alu_op;

`ifdef UC_MEM_HANDSHAKE_EN
  assign w_mem_ok = i_mem_ready;
`else
  // Memory always completes in one cycle; the OR keeps the unused port referenced.
  assign w_mem_ok = i_mem_ready | 1'b1;
`endif

  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_state_next = w_mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW:    w_state_next = S_MEMADDR;
          OP_RTYPE:        w_state_next = S_EXEC_R;
          OP_IARTH:        w_state_next = S_EXEC_I;
          OP_LWI:          w_state_next = S_LOADIMM;
          OP_BEQ, OP_BNE:  w_state_next = S_BRANCH;
          OP_J:            w_state_next = S_JUMP;
          default:         w_state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADDR:  w_state_next = (r_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_state_next = w_mem_ok ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_state_next = w_mem_ok ? S_FETCH : S_MEMWRITE;
      S_EXEC_R,
      S_EXEC_I:   w_state_next = S_ALUWB;
      S_LOADIMM:  w_state_next = S_LIWB;
      default:    w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE)
        r_opcode <= i_opcode;
    end
  end

  // Reset forces every output low, including the debug state.
  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_branch_ne     = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = 2'b00;
    o_pc_source     = 2'b00;
    w_alu_op        = 2'b00;
    o_illegal_op    = 1'b0;
    o_instr_done    = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        S_FETCH: begin
          o_mem_read  = 1'b1;
          o_ir_write  = w_mem_ok;
          o_pc_write  = w_mem_ok;
          o_alu_src_b = 2'b01;
        end
        S_DECODE:   o_alu_src_b = 2'b11;
        S_MEMADDR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
        end
        S_LOADIMM: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
          w_alu_op    = 2'b01;
        end
        S_MEMREAD: begin
          o_mem_read = 1'b1;
          o_iord     = 1'b1;
        end
        S_MEMWRITE: begin
          o_mem_write  = 1'b1;
          o_iord       = 1'b1;
          o_instr_done = w_mem_ok;
        end
        S_MEMWB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
          o_instr_done = 1'b1;
        end
        S_EXEC_R: begin
          o_alu_src_a = 1'b1;
          w_alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
          w_alu_op    = 2'b10;
        end
        S_ALUWB: begin
          o_reg_write  = 1'b1;
          o_reg_dst    = 1'b1;
          o_instr_done = 1'b1;
        end
        S_LIWB: begin
          o_reg_write  = 1'b1;
          o_instr_done = 1'b1;
        end
        S_BRANCH: begin
          o_alu_src_a     = 1'b1;
          w_alu_op        = 2'b01;
          o_pc_write_cond = 1'b1;
          o_pc_source     = 2'b01;
          o_branch_ne     = (r_opcode == OP_BNE);
          o_instr_done    = 1'b1;
        end
        S_JUMP: begin
          o_pc_write   = 1'b1;
          o_pc_source  = 2'b10;
          o_instr_done = 1'b1;
        end
        S_ILLEGAL: begin
          o_illegal_op = 1'b1;
          o_instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_alu_op = ALUOP_W'(w_alu_op);
  assign o_state  = i_rst_n ? r_state : '0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed vector bench for multicycle_control_unit; exercises the wait-state path when
// UC_MEM_HANDSHAKE_EN is defined, otherwise checks that mem_ready is ignored.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [3:0] exp_state;
    ctrl_t      exp_ctrl;
    string      name;
  } vec_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_I   = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b100010;
  localparam logic [5:0] OP_LWI = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000110;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

`ifdef UC_MEM_HANDSHAKE_EN
  localparam logic MR = 1'b1;
`else
  localparam logic MR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;
  ctrl_t      act;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_pc_write, cnt_mem_write, cnt_reg_write;

  ctrl_t e_zero, e_fetch, e_fetch_wait, e_decode, e_memaddr, e_memread, e_memwb, e_memwrite;
  ctrl_t e_memwrite_wait, e_exec_r, e_exec_i, e_aluwb, e_loadimm, e_liwb, e_beq, e_bne;
  ctrl_t e_jump, e_illegal;
  vec_t  vecs[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUOP_W(2), .STATE_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_mem_ready(mem_ready),
    .o_pc_write(pc_write), .o_pc_write_cond(pc_write_cond), .o_branch_ne(branch_ne),
    .o_iord(iord), .o_mem_read(mem_read), .o_mem_write(mem_write), .o_ir_write(ir_write),
    .o_mem_to_reg(mem_to_reg), .o_reg_dst(reg_dst), .o_reg_write(reg_write),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_pc_source(pc_source),
    .o_alu_op(alu_op), .o_illegal_op(illegal_op), .o_instr_done(instr_done), .o_state(state)
  );

  assign act = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op,
                illegal_op, instr_done};

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input ctrl_t c, input string nm);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.mem_ready = mr; v.exp_state = st; v.exp_ctrl = c; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] es, input ctrl_t ec, input string nm);
    @(negedge clk);
    rst_n = r; opcode = op; mem_ready = mr;
    #1;
    $display("[TB] %-14s rst_n=%0b op=%b mr=%0b state=%0d ctrl=%h", nm, r, op, mr, state, act);
    n_tests++;
    if (state !== es) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", nm, state, es);
    end
    n_tests++;
    if (act !== ec) begin
      n_fail++;
      $display("FAIL %s controls: got %h expected %h", nm, act, ec);
    end
    cnt_pc_write  += int'(act.pc_write);
    cnt_mem_write += int'(act.mem_write);
    cnt_reg_write += int'(act.reg_write);
  endtask

  task automatic check_count(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    e_zero = '0;
    e_fetch = '0;      e_fetch.pc_write = 1; e_fetch.mem_read = 1; e_fetch.ir_write = 1;
                       e_fetch.alu_src_b = 2'b01;
    e_fetch_wait = '0; e_fetch_wait.mem_read = 1; e_fetch_wait.alu_src_b = 2'b01;
    e_decode = '0;     e_decode.alu_src_b = 2'b11;
    e_memaddr = '0;    e_memaddr.alu_src_a = 1; e_memaddr.alu_src_b = 2'b10;
    e_loadimm = '0;    e_loadimm.alu_src_a = 1; e_loadimm.alu_src_b = 2'b10; e_loadimm.alu_op = 2'b01;
    e_memread = '0;    e_memread.mem_read = 1; e_memread.iord = 1;
    e_memwrite = '0;   e_memwrite.mem_write = 1; e_memwrite.iord = 1; e_memwrite.instr_done = 1;
    e_memwrite_wait = '0; e_memwrite_wait.mem_write = 1; e_memwrite_wait.iord = 1;
    e_memwb = '0;      e_memwb.reg_write = 1; e_memwb.mem_to_reg = 1; e_memwb.instr_done = 1;
    e_exec_r = '0;     e_exec_r.alu_src_a = 1; e_exec_r.alu_op = 2'b10;
    e_exec_i = '0;     e_exec_i.alu_src_a = 1; e_exec_i.alu_src_b = 2'b10; e_exec_i.alu_op = 2'b10;
    e_aluwb = '0;      e_aluwb.reg_write = 1; e_aluwb.reg_dst = 1; e_aluwb.instr_done = 1;
    e_liwb = '0;       e_liwb.reg_write = 1; e_liwb.instr_done = 1;
    e_beq = '0;        e_beq.alu_src_a = 1; e_beq.alu_op = 2'b01; e_beq.pc_write_cond = 1;
                       e_beq.pc_source = 2'b01; e_beq.instr_done = 1;
    e_bne = e_beq;     e_bne.branch_ne = 1;
    e_jump = '0;       e_jump.pc_write = 1; e_jump.pc_source = 2'b10; e_jump.instr_done = 1;
    e_illegal = '0;    e_illegal.illegal_op = 1; e_illegal.instr_done = 1;

    for (int i = 0; i < 3; i++) add(0, OP_LW, MR, 0, e_zero, "reset");
    add(1, OP_LW,  MR, 0,  e_fetch,   "lw_fetch");
    add(1, OP_LW,  MR, 1,  e_decode,  "lw_decode");
    add(1, OP_LW,  MR, 2,  e_memaddr, "lw_memaddr");
    add(1, OP_LW,  MR, 3,  e_memread, "lw_memread");
    add(1, OP_LW,  MR, 4,  e_memwb,   "lw_memwb");
    add(1, OP_BNE, MR, 0,  e_fetch,   "bne_fetch");
    add(1, OP_BNE, MR, 1,  e_decode,  "bne_decode");
    add(1, OP_BNE, MR, 11, e_bne,     "bne_branch");
    add(1, OP_BEQ, MR, 0,  e_fetch,   "beq_fetch");
    add(1, OP_BEQ, MR, 1,  e_decode,  "beq_decode");
    add(1, OP_BEQ, MR, 11, e_beq,     "beq_branch");
    add(1, OP_BAD, MR, 0,  e_fetch,   "bad_fetch");
    add(1, OP_BAD, MR, 1,  e_decode,  "bad_decode");
    add(1, OP_BAD, MR, 13, e_illegal, "bad_illegal");
    add(1, OP_R,   MR, 0,  e_fetch,   "r_fetch");
    add(1, OP_R,   MR, 1,  e_decode,  "r_decode");
    add(1, OP_R,   MR, 6,  e_exec_r,  "r_exec");
    add(1, OP_R,   MR, 8,  e_aluwb,   "r_aluwb");
    add(1, OP_I,   MR, 0,  e_fetch,   "i_fetch");
    add(1, OP_I,   MR, 1,  e_decode,  "i_decode");
    add(1, OP_I,   MR, 7,  e_exec_i,  "i_exec");
    add(1, OP_I,   MR, 8,  e_aluwb,   "i_aluwb");
    add(1, OP_LWI, MR, 0,  e_fetch,   "lwi_fetch");
    add(1, OP_LWI, MR, 1,  e_decode,  "lwi_decode");
    add(1, OP_LWI, MR, 9,  e_loadimm, "lwi_loadimm");
    add(1, OP_LWI, MR, 10, e_liwb,    "lwi_liwb");
    // Opcode changes after DECODE must not redirect the store.
    add(1, OP_R,   MR, 0,  e_fetch,   "sw_fetch");
    add(1, OP_SW,  MR, 1,  e_decode,  "sw_decode");
    add(1, OP_LW,  MR, 2,  e_memaddr, "sw_memaddr");
    add(1, OP_LW,  MR, 5,  e_memwrite,"sw_memwrite");
    add(1, OP_J,   MR, 0,  e_fetch,   "j_fetch");
    add(1, OP_J,   MR, 1,  e_decode,  "j_decode");
    add(1, OP_J,   MR, 12, e_jump,    "j_jump");

    foreach (vecs[i])
      step(vecs[i].rst_n, vecs[i].opcode, vecs[i].mem_ready, vecs[i].exp_state,
           vecs[i].exp_ctrl, vecs[i].name);

    // Reset dropped during EXEC_R: nothing may be written back.
    cnt_reg_write = 0;
    step(1, OP_R, MR, 0, e_fetch,  "abort_fetch");
    step(1, OP_R, MR, 1, e_decode, "abort_decode");
    step(0, OP_R, MR, 0, e_zero,   "abort_exec_r");
    step(0, OP_R, MR, 0, e_zero,   "abort_hold");
    step(1, OP_R, MR, 0, e_fetch,  "abort_refetch");
    check_count("abort_reg_write", cnt_reg_write, 0);

`ifdef UC_MEM_HANDSHAKE_EN
    cnt_pc_write = 0;
    cnt_mem_write = 0;
    step(1, OP_SW, 1, 1, e_decode, "hs_decode0");
    step(1, OP_SW, 1, 2, e_memaddr, "hs_memaddr0");
    step(1, OP_SW, 1, 5, e_memwrite, "hs_memwrite0");
    cnt_pc_write = 0;
    cnt_mem_write = 0;
    step(1, OP_SW, 0, 0, e_fetch_wait,    "hs_fetch_w1");
    step(1, OP_SW, 0, 0, e_fetch_wait,    "hs_fetch_w2");
    step(1, OP_SW, 1, 0, e_fetch,         "hs_fetch_rdy");
    step(1, OP_SW, 0, 1, e_decode,        "hs_decode");
    step(1, OP_SW, 0, 2, e_memaddr,       "hs_memaddr");
    step(1, OP_SW, 0, 5, e_memwrite_wait, "hs_memwr_w1");
    step(1, OP_SW, 0, 5, e_memwrite_wait, "hs_memwr_w2");
    step(1, OP_SW, 0, 5, e_memwrite_wait, "hs_memwr_w3");
    step(1, OP_SW, 1, 5, e_memwrite,      "hs_memwr_rdy");
    check_count("hs_pc_write_cycles", cnt_pc_write, 1);
    check_count("hs_mem_write_cycles", cnt_mem_write, 4);
    step(1, OP_SW, 0, 0, e_fetch_wait,    "hs_next_fetch");
`else
    // mem_ready low has no effect without the handshake.
    step(1, OP_J, 1'b0, 1,  e_decode, "nohs_decode");
    step(1, OP_J, 1'b0, 12, e_jump,   "nohs_jump");
    step(1, OP_J, 1'b0, 0,  e_fetch,  "nohs_fetch");
    step(1, OP_SW, 1'b0, 1, e_decode, "nohs_sw_dec");
    step(1, OP_SW, 1'b0, 2, e_memaddr, "nohs_sw_addr");
    step(1, OP_SW, 1'b0, 5, e_memwrite, "nohs_sw_wr");
    step(1, OP_SW, 1'b0, 0, e_fetch,  "nohs_refetch");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style control FSM for the multi-cycle MIPS datapath. It replaces the single-cycle opcode decoder. Each instruction is sequenced over 3–5 clock cycles, so the datapath can share one memory port and one ALU. The block sits between the instruction register (opcode input) and every datapath enable/mux select, with optional wait-state support for slow memory.

## Interface
- `ALUOP_W`, 2: width of `alu_op`.
- `STATE_W`, 4: width of the state register and the `state` debug port (must be ≥4).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `opcode`  in  6  instruction[31:26] from the instruction register; valid from the DECODE cycle onward.
- `mem_ready`  in  1  memory access complete (used only with `UC_MEM_HANDSHAKE_EN`).
- `pc_write`, `pc_write_cond`, `branch_ne`, `iord`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath controls.
- `alu_src_b`  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `pc_source`  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- `alu_op`  out  ALUOP_W  00=add, 01=sub, 10=funct-decoded; upper bits zero.
- `illegal_op`  out  1  one-cycle pulse on an undecodable opcode.
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction.
- `state`  out  STATE_W  current state, for debug.

## Operation
- Opcodes: 000000 R-type, 000001 I-arith, 100010 lw, 100011 lwi (load immediate), 101010 sw, 000100 beq, 000110 bne, 000010 j. Every other opcode is illegal.
- States and encoding:
  - FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5.
  - EXEC_R=6, EXEC_I=7, ALUWB=8, LOADIMM=9, LIWB=10.
  - BRANCH=11, JUMP=12, ILLEGAL=13.
- Transitions:
  - FETCH→DECODE.
  - DECODE dispatches on `opcode`: lw/sw→MEMADDR, R→EXEC_R, I-arith→EXEC_I, lwi→LOADIMM, beq/bne→BRANCH, j→JUMP, other→ILLEGAL.
  - MEMADDR→MEMREAD (lw) or MEMWRITE (sw); MEMREAD→MEMWB.
  - EXEC_R and EXEC_I→ALUWB; LOADIMM→LIWB.
  - MEMWB, MEMWRITE, ALUWB, LIWB, BRANCH, JUMP and ILLEGAL→FETCH.
- `opcode` is registered in DECODE. Later states use the registered copy (lw/sw and beq/bne selection).
- Outputs per state. Any control not listed is 0.
  - FETCH: mem_read=1, iord=0, ir_write=1, pc_write=1, alu_src_b=01, alu_op=00.
  - DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - MEMADDR and LOADIMM: alu_src_a=1, alu_src_b=10; alu_op=00 in MEMADDR, 01 in LOADIMM.
  - MEMREAD: mem_read=1, iord=1. MEMWRITE: mem_write=1, iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10.
  - ALUWB: reg_write=1, reg_dst=1. LIWB: reg_write=1, reg_dst=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; branch_ne=1 for bne.
  - JUMP: pc_write=1, pc_source=10. ILLEGAL: illegal_op=1.
- `instr_done`=1 in MEMWB, MEMWRITE, ALUWB, LIWB, BRANCH, JUMP and ILLEGAL.

## Timing
- Reset: on a rising edge with rst_n=0, state←FETCH and the registered opcode←0.
- While rst_n=0, every output is forced to 0, including `state`.
- The first FETCH is the cycle after rst_n returns to 1.
- Deasserting rst_n mid-instruction aborts the instruction; nothing is written back.
- Cycles per instruction without wait states: R=4, I-arith=4, lw=5, sw=4, lwi=4, beq/bne=3, j=3, illegal=3.
- All outputs are a function of state only, except the mem_ready gating below. No output depends combinationally on `opcode`.

## Configuration
- `UC_MEM_HANDSHAKE_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold until `mem_ready`=1 at a rising edge.
  - In FETCH, `pc_write` and `ir_write` are ANDed with `mem_ready`.
  - mem_read, mem_write and iord stay asserted for the whole wait.
- Undefined: `mem_ready` is ignored and each memory state lasts exactly one cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs 0. Release → state=0 with mem_read=1, ir_write=1, pc_write=1.
- opcode=100010 (lw) → states 0,1,2,3,4. MEMWB shows reg_write=1 and mem_to_reg=1. `instr_done` pulses once. Back to 0 after 5 cycles.
- opcode=000110 (bne) → states 0,1,11. BRANCH shows pc_write_cond=1, branch_ne=1, alu_op=01, pc_source=01. Same sequence with 000100 (beq) → branch_ne=0.
- opcode=111111 → states 0,1,13. `illegal_op` pulses exactly 1 cycle, reg_write and mem_write stay 0, then FETCH.
- With `UC_MEM_HANDSHAKE_EN`, sw with mem_ready low for 2 cycles in FETCH and 3 in MEMWRITE:
  - FETCH lasts 3 cycles; pc_write is seen only in the cycle mem_ready=1.
  - mem_write=1 for 4 cycles; total 9 cycles.
- Drop rst_n in EXEC_R → next edge gives state=0 with outputs forced 0; reg_write never asserted.
